rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Round-robin scheduler that shares the single 8-bit LFSR random number generator between up to N_REQ requesters. It owns the generator's `start` (step-enable) input and advances the LFSR a fixed number of steps per draw to decorrelate consecutive values. It then hands the resulting byte to exactly one requester with a one-cycle grant/valid pulse. It sits between the game-control logic (pattern generator, timers, display effects) and the LFSR.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8).
- STEPS, 3, LFSR advances per draw (1..15). Out-of-range values are an elaboration error.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable. When low, no new draw is started; an in-flight draw completes.
- req  input  N_REQ  per-requester draw request; level-sensitive.
- rng_out  input  8  current LFSR value; registered in the generator.
- rng_start  output  1  step-enable to the LFSR; high only in STEP.
- gnt  output  N_REQ  one-hot grant; high only in DELIVER.
- valid  output  1  high only in DELIVER; equals |gnt.
- data  output  8  random byte; equals rng_out during DELIVER, 0 otherwise.
- busy  output  1  high in STEP and DELIVER.

## Operation
- FSM states: IDLE, STEP, DELIVER.
- **IDLE**
  - If en=1 and req≠0, select the first asserted req index found by searching upward, with wrap, starting at last+1.
  - Latch the selected index in sel, load cnt=STEPS, and go to STEP.
  - Otherwise stay in IDLE.
- **STEP**
  - rng_start=1; cnt decrements each cycle.
  - When cnt=1 in the current cycle, go to DELIVER.
  - STEP therefore lasts exactly STEPS cycles.
- **DELIVER**
  - valid=1, gnt=onehot(sel), data=rng_out. This is the value after the STEPS advances.
  - Set last<=sel and go to IDLE.
- Round-robin pointer `last`:
  - Width clog2(N_REQ); reset value N_REQ-1, so index 0 has first priority after reset.
  - Updated only in DELIVER.
- A requester that keeps req high after its grant is re-arbitrated behind all other active requesters.
- If req drops during STEP, the draw still completes and gnt still pulses to sel; the value is discarded by the requester.
- en falling during STEP/DELIVER has no effect on the in-flight draw.
- The controller never drives the generator's reset. LFSR reseeding is the system reset's job.

## Timing
- Reset values:
  - state=IDLE, cnt=0, last=N_REQ-1, sel=0.
  - rng_start=0, gnt=0, valid=0, data=0, busy=0.
- All outputs decode from registered state with no req→output combinational path. data is the one exception: it is muxed from rng_out, which is itself registered.
- Latency: req seen high in an IDLE cycle t → rng_start high in cycles t+1..t+STEPS → gnt/valid high in cycle t+STEPS+1 → IDLE at t+STEPS+2.
- Throughput: one draw per STEPS+2 cycles with continuous requests. There is no back-to-back DELIVER.
- Simultaneous requests: only one grant per draw; the others wait in priority order.
- Reset asserted mid-draw: immediate return to IDLE with all outputs 0, and last restored to N_REQ-1. The partial LFSR advance is not undone.
- rng_start is never high outside STEP. The LFSR is stepped exactly STEPS times per delivered byte, never between draws.

## Test plan
- **Reset then single request.** Release rst; hold req=4'b0010 (STEPS=3) from cycle 0. Required:
  - rng_start high in cycles 1-3.
  - gnt=4'b0010, valid=1 in cycle 4.
  - data equals the bench LFSR model after 3 steps from seed.
  - busy low in cycle 5.
- **All four requesting continuously (req=4'b1111).** Grants occur in order 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart. Each data equals the model advanced by 3 more steps.
- **Priority wrap.** After granting index 3, assert req=4'b1001. The grant goes to index 0; the next grant, with req still 4'b1001, goes to index 3.
- **Enable gating.** Hold en=0 with req=4'b0100 for 10 cycles: rng_start and gnt stay 0. Raise en: the grant arrives STEPS+1 cycles later. Dropping en in the middle of STEP still yields a DELIVER.
- **Request withdrawn mid-draw.** Pulse req[2] for one cycle only. gnt=4'b0100 is still issued in cycle STEPS+1, and no second draw follows.
- **Asynchronous reset mid-draw.** Assert rst in the second STEP cycle, between clock edges. All outputs go 0 immediately. After release, req=4'b1111 is granted to index 0 first.

Source files
------------

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin scheduler sharing one 8-bit LFSR among N_REQ requesters
// Each draw steps the LFSR STEPS times, then delivers the byte to one requester for a single cycle.
module rng_arbiter #(
  parameter int N_REQ = 4,
  parameter int STEPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [7:0]       rng_out,
  output logic             rng_start,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic [7:0]       data,
  output logic             busy
);

  localparam int LW = $clog2(N_REQ);

  if (STEPS < 1 || STEPS > 15) begin : g_bad_steps
    $error("rng_arbiter: STEPS must be in 1..15");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("rng_arbiter: N_REQ must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   sel_q, sel_d;

  logic            pick_found;
  logic [LW-1:0]   pick_idx;
  logic [LW-1:0]   idx;

  // Search upward from last+1 with wrap; the most recent winner is checked last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = LW'((int'(last_q) + i) % N_REQ);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          sel_d   = pick_idx;
          cnt_d   = 4'(STEPS);
          state_d = STEP;
        end
      end
      STEP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= LW'(N_REQ - 1);
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // Outputs decode only from registered state; data passes the already-registered LFSR value.
  assign rng_start = (state_q == STEP);
  assign valid     = (state_q == DELIVER);
  assign gnt       = valid ? (N_REQ'(1) << sel_q) : '0;
  assign data      = valid ? rng_out : 8'd0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - self-checking bench for rng_arbiter
// Includes a behavioural LFSR as the shared generator and a grant/data scoreboard.
module tb_rng_arbiter;

  localparam int N_REQ = 4;
  localparam int STEPS = 3;
  localparam logic [7:0] SEED = 8'h01;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N_REQ-1:0] req;
  logic [7:0]       rng_out;
  logic             rng_start;
  logic [N_REQ-1:0] gnt;
  logic             valid;
  logic [7:0]       data;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  lfsr_q;
  logic [7:0]  mdl;
  logic [11:0] exp_q[$];

  rng_arbiter #(.N_REQ(N_REQ), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .rng_out(rng_out),
    .rng_start(rng_start), .gnt(gnt), .valid(valid), .data(data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Shared generator: reseeded by system reset, advanced only on rng_start.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else if (rng_start) lfsr_q <= lfsr_next(lfsr_q);
  end
  assign rng_out = lfsr_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [N_REQ-1:0] g);
    for (int i = 0; i < STEPS; i++) mdl = lfsr_next(mdl);
    exp_q.push_back({g, mdl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 20);
    chk("grant_arrived", valid, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    tick();
    tick();
    chk("rst_rng_start", rng_start, 1'b0);
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    mdl = SEED;
    exp_q.delete();
  endtask

  // Monitor: scoreboard pops on every delivery plus per-cycle output invariants.
  int steps_seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      steps_seen = 0;
    end else begin
      if (rng_start) steps_seen++;
      if (valid) begin
        chk("steps_per_draw", steps_seen, STEPS);
        steps_seen = 0;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_valid", valid, 1'b0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          chk("sb_gnt", gnt, e[11:8]);
          chk("sb_data", data, e[7:0]);
        end
      end else begin
        chk("idle_data_zero", data, 8'h00);
      end
      chk("valid_eq_or_gnt", valid, |gnt);
      chk("busy_decode", busy, rng_start | valid);
    end
  end

  typedef struct {
    logic             en;
    logic [N_REQ-1:0] req;
    logic             start;
    logic [N_REQ-1:0] gnt;
    logic             busy;
  } vec_t;

  vec_t tbl[7];
  int   n;

  initial begin
    tbl[0] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1};
    tbl[2] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1};
    tbl[3] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1};
    tbl[5] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[6] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};

    // Reset then single request, cycle by cycle.
    do_reset();
    push_exp(4'b0010);
    for (int i = 0; i < 7; i++) begin
      en  = tbl[i].en;
      req = tbl[i].req;
      #1;
      chk($sformatf("t1_start_c%0d", i), rng_start, tbl[i].start);
      chk($sformatf("t1_gnt_c%0d", i), gnt, tbl[i].gnt);
      chk($sformatf("t1_valid_c%0d", i), valid, |tbl[i].gnt);
      chk($sformatf("t1_busy_c%0d", i), busy, tbl[i].busy);
      tick();
    end

    // All four requesting continuously.
    do_reset();
    en  = 1'b1;
    req = 4'b1111;
    push_exp(4'b0001);
    push_exp(4'b0010);
    push_exp(4'b0100);
    push_exp(4'b1000);
    push_exp(4'b0001);
    next_grant(n);
    chk("t2_first_latency", n, STEPS + 1);
    for (int i = 0; i < 4; i++) begin
      next_grant(n);
      chk("t2_spacing", n, STEPS + 2);
    end

    // Priority wrap around index 3.
    req = 4'b1000;
    push_exp(4'b1000);
    next_grant(n);
    chk("t3_gnt3", gnt, 4'b1000);
    req = 4'b1001;
    push_exp(4'b0001);
    push_exp(4'b1000);
    next_grant(n);
    chk("t3_wrap_to0", gnt, 4'b0001);
    next_grant(n);
    chk("t3_back_to3", gnt, 4'b1000);
    req = 4'b0000;

    // Enable gating, then en dropped mid-STEP.
    en  = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_gated_start", rng_start, 1'b0);
      chk("t4_gated_gnt", gnt, 4'b0);
    end
    en = 1'b1;
    push_exp(4'b0100);
    next_grant(n);
    chk("t4_en_latency", n, STEPS + 1);
    push_exp(4'b0100);
    tick();
    tick();
    chk("t4_in_step", rng_start, 1'b1);
    en = 1'b0;
    next_grant(n);
    chk("t4_en_drop_completes", n, STEPS);
    chk("t4_en_drop_gnt", gnt, 4'b0100);
    req = 4'b0000;
    en  = 1'b1;

    // One-cycle request pulse still completes exactly one draw.
    tick();
    req = 4'b0100;
    push_exp(4'b0100);
    tick();
    req = 4'b0000;
    next_grant(n);
    chk("t5_pulse_latency", n + 1, STEPS + 1);
    chk("t5_pulse_gnt", gnt, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_no_second_draw", busy, 1'b0);
    end

    // Asynchronous reset in the second STEP cycle.
    req = 4'b1111;
    tick();
    tick();
    chk("t6_in_step", rng_start, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_start", rng_start, 1'b0);
    chk("t6_async_gnt", gnt, 4'b0);
    chk("t6_async_valid", valid, 1'b0);
    chk("t6_async_data", data, 8'h00);
    chk("t6_async_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    mdl = SEED;
    chk("t6_queue_empty", exp_q.size(), 0);
    push_exp(4'b0001);
    next_grant(n);
    chk("t6_latency", n, STEPS + 1);
    chk("t6_first_after_rst", gnt, 4'b0001);
    req = 4'b0000;

    for (int i = 0; i < 6; i++) tick();
    chk("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
